mm_bank_arbiter: RTL and testbench
==================================

// Module: mm_bank_arbiter
// PURPOSE
// - Shares one MM_top Montgomery multiplier and its bridge BRAM between NREQ requesters.
// - Round-robin grant; fires MM_top start_i; waits for MM_top done_o; returns a done pulse to the winner.
// - Adds the granted requester's bank index above the MM_top BRAM address. Each requester owns
//   one 4*s-word region (operands p'_0, p, a, b in; RES out) in a shared BRAM.
// PARAMETERS
// - NREQ           4      number of requesters, 2..16
// - s              8      operand words of 17 bits; must match MM_top s
// - TIMEOUT_CYCLES 4096   watchdog limit in cycles (used only with MM_ARB_WATCHDOG_EN)
// - AW = $clog2(4*s), BW = $clog2(NREQ)   localparams
// PORTS
// - clock_i        in   1     clock, rising edge
// - reset_i        in   1     synchronous, active-high reset
// - req_i          in   NREQ  level request per requester; held until its done_o pulse
// - gnt_o          out  NREQ  one-hot grant, held from GRANT until RELEASE inclusive
// - done_o         out  NREQ  1-cycle pulse to the granted requester; RES is in its bank
// - err_o          out  NREQ  1-cycle pulse with done_o on watchdog abort (0 without macro)
// - mm_start_o     out  1     to MM_top start_i
// - mm_reset_o     out  1     to MM_top reset_i
// - mm_done_i      in   1     from MM_top done_o
// - mm_addr_i      in   32    MM_top BRAM_addr_o; only [AW-1:0] used
// - mm_we_i/mm_en_i in  1     MM_top BRAM_we_o / BRAM_en_o
// - bram_addr_o    out  32    {zeros, bank, mm_addr_i[AW-1:0]}; bank = granted index
// - bram_we_o/bram_en_o out 1 mm_we_i / mm_en_i gated by (state==START||state==BUSY)
// - busy_o         out  1     state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE, gnt_o/done_o/err_o/mm_start_o=0, bank=0, rr_ptr=0, busy_o=0;
//   mm_reset_o=reset_i (combinational OR with the abort pulse).
// - FSM:
//   - IDLE: if |req_i, pick the first set req at index rr_ptr, rr_ptr+1, ... (mod NREQ).
//     Latch bank; go to GRANT.
//   - GRANT: 1 cycle; gnt_o asserted; BRAM enables held 0.
//   - START: mm_start_o=1 for exactly 1 cycle; go to BUSY.
//   - BUSY: wait for mm_done_i=1 (any single cycle); go to RELEASE.
//   - RELEASE: done_o[bank]=1 for 1 cycle; rr_ptr<=bank+1 (wraps NREQ-1 -> 0); go to IDLE.
// - Latency: req_i rise in IDLE -> mm_start_o 2 cycles later. mm_done_i -> done_o next cycle.
//   Min IDLE dwell is 1 cycle between jobs.
// - req_i changes after grant are ignored until RELEASE; a dropped request still completes.
// - mm_done_i outside BUSY is ignored. A new arbitration uses req_i sampled in IDLE only.
// - A requester re-requesting right after its done_o loses to any other pending requester
//   (fairness: max wait is NREQ-1 jobs).
// - Address/bank values are stable from GRANT to RELEASE. The bank is never changed mid-job.
// - reset_i mid-job: immediate return to IDLE; no done_o is issued; the MM_top is reset too.
// CONFIGURATION
// - `MM_ARB_WATCHDOG_EN defined:
//   - 32-bit counter cleared on entry to BUSY.
//   - If it reaches TIMEOUT_CYCLES with no mm_done_i: mm_reset_o=1 for 2 cycles;
//     done_o[bank] and err_o[bank] pulse together; rr_ptr advances; state goes to IDLE
//     after the reset pulse.
//   - mm_done_i on the same cycle as the timeout: the done wins (no error).
// - Not defined: no counter; BUSY waits indefinitely; err_o tied 0; mm_reset_o=reset_i.
// TESTING
// - Single req_i=4'b0100: gnt_o=4'b0100; mm_start_o 2 cycles later; done_o[2] 1 cycle after
//   mm_done_i. bram_addr_o = 2*32 + mm_addr_i[4:0] (s=8).
// - req_i=4'b1111 held: grants go 0,1,2,3,0 in order. Each grant gets exactly one
//   mm_start_o and one done_o.
// - Requester 3 drops req_i during BUSY: the job completes and done_o[3] still pulses.
//   The next grant follows the round-robin order from 0.
// - reset_i asserted 10 cycles into BUSY: the next cycle shows gnt_o=0, busy_o=0,
//   and no done_o; the following request runs normally.
// - MM_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=16, mm_done_i held 0: at 16 cycles mm_reset_o pulses
//   2 cycles, and done_o/err_o pulse for that bank. With mm_done_i at cycle 16: err_o stays 0.
// - mm_done_i pulsed while IDLE: no state change and no done_o.

Source files
------------

// File: rtl/mm_bank_arbiter.sv
// Round-robin arbiter sharing one MM_top Montgomery multiplier and its bridge BRAM among NREQ
// requesters. Define MM_ARB_WATCHDOG_EN to enable the BUSY-state watchdog abort.
module mm_bank_arbiter #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned s              = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] done_o,
  output logic [NREQ-1:0] err_o,
  output logic            mm_start_o,
  output logic            mm_reset_o,
  input  logic            mm_done_i,
  input  logic [31:0]     mm_addr_i,
  input  logic            mm_we_i,
  input  logic            mm_en_i,
  output logic [31:0]     bram_addr_o,
  output logic            bram_we_o,
  output logic            bram_en_o,
  output logic            busy_o
);

  localparam int unsigned AW = $clog2(4 * s);
  localparam int unsigned BW = $clog2(NREQ);

  typedef enum logic [2:0] {
    StIdle, StGrant, StStart, StBusy, StRelease, StAbort1, StAbort2
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   bank_q, bank_d;
  logic [BW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            start_q, start_d;
  logic [BW-1:0]   pick, cand, nxt_ptr;
  logic            found;

`ifdef MM_ARB_WATCHDOG_EN
  logic [NREQ-1:0] err_q, err_d;
  logic [31:0]     wd_q, wd_d;
  logic            wd_rst_q, wd_rst_d;
`endif

  assign nxt_ptr = (32'(bank_q) == NREQ - 1) ? '0 : bank_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    start_d  = 1'b0;
    pick     = '0;
    cand     = '0;
    found    = 1'b0;
`ifdef MM_ARB_WATCHDOG_EN
    err_d    = '0;
    wd_d     = wd_q;
    wd_rst_d = 1'b0;
`endif

    // First set request at rr_ptr, rr_ptr+1, ... wrapping at NREQ.
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = BW'((32'(rr_ptr_q) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    case (state_q)
      StIdle: begin
        if (found) begin
          bank_d  = pick;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        start_d = 1'b1;
        state_d = StStart;
      end
      StStart: begin
`ifdef MM_ARB_WATCHDOG_EN
        wd_d = '0;
`endif
        state_d = StBusy;
      end
      StBusy: begin
        if (mm_done_i) begin
          done_d[bank_q] = 1'b1;
          state_d        = StRelease;
        end
`ifdef MM_ARB_WATCHDOG_EN
        else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
          done_d[bank_q] = 1'b1;
          err_d[bank_q]  = 1'b1;
          wd_rst_d       = 1'b1;
          state_d        = StAbort1;
        end else begin
          wd_d = wd_q + 32'd1;
        end
`endif
      end
      StRelease: begin
        rr_ptr_d = nxt_ptr;
        gnt_d    = '0;
        state_d  = StIdle;
      end
`ifdef MM_ARB_WATCHDOG_EN
      // Hold MM_top in reset for a second cycle before returning to IDLE.
      StAbort1: begin
        wd_rst_d = 1'b1;
        rr_ptr_d = nxt_ptr;
        state_d  = StAbort2;
      end
      StAbort2: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      bank_q   <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
`ifdef MM_ARB_WATCHDOG_EN
      err_q    <= '0;
      wd_q     <= '0;
      wd_rst_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      start_q  <= start_d;
`ifdef MM_ARB_WATCHDOG_EN
      err_q    <= err_d;
      wd_q     <= wd_d;
      wd_rst_q <= wd_rst_d;
`endif
    end
  end

  logic mm_active;
  assign mm_active = (state_q == StStart) || (state_q == StBusy);

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign mm_start_o  = start_q;
  assign busy_o      = (state_q != StIdle);
  assign bram_addr_o = 32'({bank_q, mm_addr_i[AW-1:0]});
  assign bram_we_o   = mm_we_i & mm_active;
  assign bram_en_o   = mm_en_i & mm_active;

`ifdef MM_ARB_WATCHDOG_EN
  assign err_o      = err_q;
  assign mm_reset_o = reset_i | wd_rst_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign err_o          = '0;
  assign mm_reset_o     = reset_i;
`endif

  logic unused_addr;
  assign unused_addr = ^mm_addr_i[31:AW];

endmodule

// File: tb/tb_mm_bank_arbiter.sv
// Self-checking bench for mm_bank_arbiter: directed vector table, hand sequences and a
// randomized run against a job-level reference model.
module tb_mm_bank_arbiter;
  localparam int N  = 4;
  localparam int S  = 8;
  localparam int TO = 16;
`ifdef MM_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [N-1:0]  req_i = '0;
  logic [N-1:0]  gnt_o, done_o, err_o;
  logic          mm_start_o, mm_reset_o, busy_o;
  logic          mm_done_i = 1'b0;
  logic [31:0]   mm_addr_i = '0;
  logic          mm_we_i = 1'b0, mm_en_i = 1'b0;
  logic [31:0]   bram_addr_o;
  logic          bram_we_o, bram_en_o;

  mm_bank_arbiter #(.NREQ(N), .s(S), .TIMEOUT_CYCLES(TO)) dut (
    .clock_i(clk), .reset_i(reset_i), .req_i(req_i), .gnt_o(gnt_o), .done_o(done_o),
    .err_o(err_o), .mm_start_o(mm_start_o), .mm_reset_o(mm_reset_o), .mm_done_i(mm_done_i),
    .mm_addr_i(mm_addr_i), .mm_we_i(mm_we_i), .mm_en_i(mm_en_i), .bram_addr_o(bram_addr_o),
    .bram_we_o(bram_we_o), .bram_en_o(bram_en_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Job-level model: a job is granted, started one cycle later, busy until done (or the
  // watchdog limit), then released; the pointer moves just past the finished owner.
  int m_act = 0, m_age = 0, m_own = 0, m_ptr = 0, m_ph = 0;

  task automatic model_step();
    int k;
    bit f;
    if (reset_i) begin
      m_act = 0; m_ph = 0; m_ptr = 0; m_own = 0;
    end else if (m_act == 0) begin
      f = 1'b0;
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (!f && (((req_i >> k) & 4'b1) != 0)) begin
          f = 1'b1; m_own = k;
        end
      end
      if (f) begin
        m_act = 1; m_age = 0; m_ph = 0;
      end
    end else if (m_ph == 1 || m_ph == 3) begin
      m_act = 0; m_ph = 0; m_ptr = (m_own + 1) % N;
    end else if (m_ph == 2) begin
      m_ph = 3;
    end else begin
      if (m_age >= 2 && mm_done_i) m_ph = 1;
      else if (WD && m_age == TO + 1) m_ph = 2;
      m_age++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model();
    logic [31:0] own_bit, e_gnt, e_done, e_err;
    logic        gate;
    own_bit = 32'd1 << m_own;
    e_gnt   = (m_act != 0) ? own_bit : 32'd0;
    e_done  = (m_ph == 1 || m_ph == 2) ? own_bit : 32'd0;
    e_err   = (m_ph == 2) ? own_bit : 32'd0;
    gate    = (m_act != 0) && (m_ph == 0) && (m_age >= 1);
    chk("rnd_gnt", 32'(gnt_o), e_gnt);
    chk("rnd_done", 32'(done_o), e_done);
    chk("rnd_err", 32'(err_o), e_err);
    chk("rnd_start", 32'(mm_start_o), 32'((m_act != 0) && (m_ph == 0) && (m_age == 1)));
    chk("rnd_busy", 32'(busy_o), 32'(m_act != 0));
    chk("rnd_mmrst", 32'(mm_reset_o), 32'(reset_i || m_ph == 2 || m_ph == 3));
    chk("rnd_addr", bram_addr_o, 32'(m_own) * 32 + (mm_addr_i & 32'd31));
    chk("rnd_en", 32'(bram_en_o), 32'(mm_en_i & gate));
    chk("rnd_we", 32'(bram_we_o), 32'(mm_we_i & gate));
  endtask

  task automatic do_reset();
    reset_i = 1'b1; req_i = '0; mm_done_i = 1'b0;
    cycle(); cycle();
    reset_i = 1'b0;
  endtask

  // Waits for a grant to bank b, answers mm_start_o with mm_done_i dly cycles later.
  task automatic run_job(input int b, input int dly, input logic [N-1:0] req_after);
    int n, starts, since;
    bit got;
    n = 0; starts = 0; since = -1; got = 1'b0;
    while (gnt_o == '0 && n < 8) begin cycle(); n++; end
    chk("job_gnt", 32'(gnt_o), 32'd1 << b);
    for (int c = 0; c < 60 && !got; c++) begin
      mm_done_i = (since == dly);
      cycle();
      if (mm_start_o) begin starts++; since = 0; req_i = req_after; end
      else if (since >= 0) since++;
      if (done_o != '0) begin
        got = 1'b1;
        chk("job_done", 32'(done_o), 32'd1 << b);
        chk("job_err", 32'(err_o), 32'd0);
      end
    end
    mm_done_i = 1'b0;
    chk("job_starts", 32'(starts), 32'd1);
    chk("job_done_seen", 32'(got), 32'd1);
    cycle();
  endtask

  typedef struct packed {
    logic [3:0] req;
    logic       md;
    logic [3:0] gnt;
    logic       st;
    logic [3:0] dn;
    logic       bsy;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int n;
    tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b1};
    tbl[2]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[3]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1};
    tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[6]  = '{4'b1010, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1};
    tbl[7]  = '{4'b1010, 1'b0, 4'b1000, 1'b1, 4'b0000, 1'b1};
    tbl[8]  = '{4'b0010, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1};
    tbl[9]  = '{4'b0010, 1'b1, 4'b1000, 1'b0, 4'b1000, 1'b1};
    tbl[10] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[11] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1};
    tbl[12] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0000, 1'b1};
    tbl[13] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1};
    tbl[14] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1};
    tbl[15] = '{4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1};
    tbl[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};

    // Reset state
    cycle(); cycle();
    chk("rst_mm_reset", 32'(mm_reset_o), 32'd1);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_outs", 32'({done_o, err_o, mm_start_o}), 32'd0);
    reset_i = 1'b0;
    #1 chk("rst_mm_reset_low", 32'(mm_reset_o), 32'd0);

    // Vector table
    mm_addr_i = 32'hABCD_1225; mm_en_i = 1'b1; mm_we_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      req_i = tbl[i].req; mm_done_i = tbl[i].md;
      cycle();
      chk($sformatf("vec%0d", i), 32'({gnt_o, mm_start_o, done_o, busy_o}),
          32'({tbl[i].gnt, tbl[i].st, tbl[i].dn, tbl[i].bsy}));
      if (i == 0) chk("vec_grant_en_gated", 32'(bram_en_o), 32'd0);
      if (i == 2) begin
        chk("vec_bank2_addr", bram_addr_o, 32'd69);
        chk("vec_busy_en", 32'({bram_en_o, bram_we_o}), 32'd3);
      end
    end
    mm_done_i = 1'b0;

    // All requesting: grants rotate 0,1,2,3,0
    do_reset();
    req_i = 4'b1111;
    for (int j = 0; j < 5; j++) run_job(j % N, 3, 4'b1111);
    req_i = '0;

    // Requester 3 drops its request mid-job; next grant restarts at 0
    do_reset();
    req_i = 4'b1000;
    run_job(3, 4, 4'b0101);
    run_job(0, 2, 4'b0000);

    // Reset ten cycles into BUSY
    do_reset();
    req_i = 4'b0001;
    n = 0;
    while (!mm_start_o && n < 10) begin cycle(); n++; end
    chk("rst_job_started", 32'(mm_start_o), 32'd1);
    for (int j = 0; j < 10; j++) cycle();
    reset_i = 1'b1;
    #1 chk("midjob_mm_reset", 32'(mm_reset_o), 32'd1);
    cycle();
    reset_i = 1'b0; req_i = 4'b0010;
    chk("midjob_after", 32'({gnt_o, busy_o, done_o}), 32'd0);
    run_job(1, 2, 4'b0000);

`ifdef MM_ARB_WATCHDOG_EN
    // Watchdog abort, then done on the final allowed BUSY cycle
    do_reset();
    req_i = 4'b0001;
    n = 0;
    while (!mm_start_o && n < 10) begin cycle(); n++; end
    n = 0;
    for (int c = 0; c < 40 && done_o == '0; c++) begin cycle(); n++; end
    chk("wd_latency", 32'(n), 32'd17);
    chk("wd_err", 32'({err_o, done_o, mm_reset_o}), 32'({4'b0001, 4'b0001, 1'b1}));
    req_i = '0;
    cycle();
    chk("wd_reset2", 32'({mm_reset_o, done_o, err_o}), 32'h100);
    cycle();
    chk("wd_idle", 32'({mm_reset_o, busy_o}), 32'd0);
    req_i = 4'b0010;
    run_job(1, 16, 4'b0000);
`endif

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset_i   = ($urandom % 300 == 0);
      mm_done_i = WD ? ($urandom % 4 == 0) : ($urandom % 5 == 0);
      mm_addr_i = $urandom;
      mm_we_i   = $urandom % 2 == 0;
      mm_en_i   = $urandom % 2 == 0;
      cycle();
      check_model();
      for (int k = 0; k < N; k++) begin
        if (done_o[k]) req_i[k] = 1'b0;
        else if (!req_i[k] && $urandom % 4 == 0) req_i[k] = 1'b1;
        else if ($urandom % 64 == 0) req_i[k] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
